next_pc_gen: RTL and testbench
==============================

// Module: next_pc_gen
// PURPOSE
//   Next-address stage directly upstream of the pc register: takes pc's current
//   address (out_add) and produces in_add for the next clk edge.
//   Handles sequential fetch, relative branch, absolute jump, call/return via a
//   small return-address stack (RAS), stall hold and halt.
//   Holds the boot/run/halt FSM for instruction sequencing.
// PARAMETERS
//   ADDR_W     5   instruction address width; matches pc in_add/out_add
//   RAS_DEPTH  4   return-address stack entries (power of 2, 2..16)
//   RESET_VEC  0   first fetch address after reset
// PORTS
//   clk          in   1        rising-edge clock (same as pc)
//   rst_n        in   1        asynchronous active-low reset
//   cur_add      in   ADDR_W   current PC (pc.out_add)
//   stall        in   1        hold PC this cycle
//   branch_take  in   1        take relative branch
//   branch_off   in   ADDR_W   signed two's-complement branch offset
//   jump         in   1        absolute jump to jump_tgt
//   jump_tgt     in   ADDR_W   jump/call target
//   call         in   1        push cur_add+1, go to jump_tgt
//   ret          in   1        pop RAS top into PC
//   halt         in   1        enter HALT permanently (until reset)
//   next_add     out  ADDR_W   drives pc.in_add (combinational from state/inputs)
//   halted       out  1        FSM in HALT
//   ras_empty    out  1        RAS count == 0
//   ras_full     out  1        RAS count == RAS_DEPTH
//   ras_ovf      out  1        sticky: call while full
//   ras_unf      out  1        sticky: ret while empty
// BEHAVIOUR
//   - Reset (async, any time incl. mid-call): state=BOOT, RAS count/ptr=0,
//     ras_ovf=ras_unf=0, halted=0; next_add=RESET_VEC while in BOOT.
//   - FSM: BOOT -> RUN after first clk edge with rst_n high (unconditional).
//     RUN -> HALT on edge where halt=1 (even if stall=1). HALT exits only by reset.
//   - HALT: next_add=cur_add; RAS and flags frozen; all controls ignored.
//   - RUN, stall=1 and halt=0: next_add=cur_add; no RAS change; other controls ignored.
//   - RUN priority (stall=0): halt > ret > call > jump > branch_take > sequential.
//       halt:   next_add=cur_add (state moves to HALT at the edge)
//       ret:    not empty -> next_add=RAS top, pop at edge
//               empty -> next_add=cur_add+1, ras_unf<=1
//       call:   next_add=jump_tgt; push cur_add+1 at edge
//               full -> overwrite oldest (circular), count stays RAS_DEPTH, ras_ovf<=1
//       jump:   next_add=jump_tgt
//       branch: next_add=cur_add+1+branch_off
//       else:   next_add=cur_add+1
//   - All arithmetic is modulo 2^ADDR_W; 2^ADDR_W-1 +1 wraps to 0, no flag.
//   - Zero added latency: next_add settles combinationally within the cycle;
//     pc captures it on the same edge as the RAS/FSM update.
//   - ret and call together: ret wins, call dropped, no push.
// CONFIGURATION
//   NEXT_PC_RAS_EN defined: RAS, call/ret semantics and ras_* flags as above.
//   Not defined: no stack storage; call acts as jump (no push); ret acts as
//   sequential; ras_empty=1, ras_full=0, ras_ovf=ras_unf=0 constant.
// TESTING
//   - Reset, release, 34 idle cycles -> next_add 0,1,2..31,0,1 (wrap); halted=0.
//   - cur_add=10, branch_take=1, off=5'b11101 (-3) -> next_add=8; off=+4 -> 15.
//   - call at 3 (tgt 20), call at 21 (tgt 25), ret, ret -> next_add 20,25,22,4;
//     ras_empty=1 after second pop.
//   - 5 calls with RAS_DEPTH=4 -> ras_full=1, ras_ovf=1; 4 rets return the
//     newest four addresses; 5th ret -> cur_add+1, ras_unf=1.
//   - stall=1 with jump=1 -> next_add=cur_add, RAS unchanged;
//     halt=1 with stall=1 -> halted=1 next cycle, next_add=cur_add thereafter.
//   - rst_n low mid-call sequence -> flags/count clear immediately (async);
//     next_add=RESET_VEC; without NEXT_PC_RAS_EN, call at 3 tgt 20, ret ->
//     next_add 20, 21.

Source files
------------

// File: rtl/next_pc_gen.sv
// rtl/next_pc_gen.sv - next-address generator with boot/run/halt FSM and optional return-address stack (NEXT_PC_RAS_EN)
module next_pc_gen #(
    parameter int ADDR_W    = 5,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_VEC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cur_add,
    input  logic              stall,
    input  logic              branch_take,
    input  logic [ADDR_W-1:0] branch_off,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_tgt,
    input  logic              call,
    input  logic              ret,
    input  logic              halt,
    output logic [ADDR_W-1:0] next_add,
    output logic              halted,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] seq_add;
    logic [ADDR_W-1:0] br_add;

    // All address arithmetic wraps modulo 2^ADDR_W by truncation.
    assign seq_add = cur_add + ADDR_ONE;
    assign br_add  = seq_add + branch_off;
    assign halted  = (state_q == ST_HALT);

`ifdef NEXT_PC_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(RAS_DEPTH);

    // ras_ptr points at the next free slot; the stack is circular so an
    // overflowing push simply overwrites the oldest entry.
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;
    logic [CNT_W-1:0]  ras_cnt;
    logic [ADDR_W-1:0] ras_top;
    logic              push;
    logic              pop;
    logic              set_unf;
    logic              ovf_q;
    logic              unf_q;

    assign ras_top   = ras_mem[ras_ptr - PTR_ONE];
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_DEPTH);
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;
`else
    // No stack storage in this build: permanently empty, never full, no flags.
    assign ras_empty = 1'b1;
    assign ras_full  = (RAS_DEPTH == 0);
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, next-address and stack-operation decode, in control priority order.
    always_comb begin
        state_d  = state_q;
        next_add = seq_add;
`ifdef NEXT_PC_RAS_EN
        push     = 1'b0;
        pop      = 1'b0;
        set_unf  = 1'b0;
`endif
        case (state_q)
            ST_BOOT: begin
                next_add = RESET_ADDR;
                state_d  = ST_RUN;
            end
            ST_HALT: begin
                next_add = cur_add;
            end
            ST_RUN: begin
                if (halt) begin
                    next_add = cur_add;
                    state_d  = ST_HALT;
                end else if (stall) begin
                    next_add = cur_add;
                end else if (ret) begin
`ifdef NEXT_PC_RAS_EN
                    if (!ras_empty) begin
                        next_add = ras_top;
                        pop      = 1'b1;
                    end else begin
                        next_add = seq_add;
                        set_unf  = 1'b1;
                    end
`else
                    next_add = seq_add;
`endif
                end else if (call) begin
                    next_add = jump_tgt;
`ifdef NEXT_PC_RAS_EN
                    push     = 1'b1;
`endif
                end else if (jump) begin
                    next_add = jump_tgt;
                end else if (branch_take) begin
                    next_add = br_add;
                end else begin
                    next_add = seq_add;
                end
            end
            default: begin
                next_add = RESET_ADDR;
                state_d  = ST_BOOT;
            end
        endcase
    end

`ifdef NEXT_PC_RAS_EN
    // Stack pointer, occupancy count and sticky overflow/underflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (push) begin
                ras_ptr <= ras_ptr + PTR_ONE;
                if (ras_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    ras_cnt <= ras_cnt + CNT_ONE;
                end
            end else if (pop) begin
                ras_ptr <= ras_ptr - PTR_ONE;
                ras_cnt <= ras_cnt - CNT_ONE;
            end
            if (set_unf) begin
                unf_q <= 1'b1;
            end
        end
    end

    // Stack storage; contents are only meaningful below ras_cnt, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[ras_ptr] <= seq_add;
        end
    end
`endif

endmodule

// File: tb/tb_next_pc_gen.sv
// tb/tb_next_pc_gen.sv - self-checking bench for next_pc_gen against a queue-based reference model
module tb_next_pc_gen;

    localparam int         AW    = 5;
    localparam int         DEPTH = 4;
    localparam logic [4:0] RV    = 5'd0;
`ifdef NEXT_PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] cur_add;
    logic          stall;
    logic          branch_take;
    logic [AW-1:0] branch_off;
    logic          jump;
    logic [AW-1:0] jump_tgt;
    logic          call;
    logic          ret;
    logic          halt;
    logic [AW-1:0] next_add;
    logic          halted;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_ovf;
    logic          ras_unf;

    next_pc_gen #(
        .ADDR_W   (AW),
        .RAS_DEPTH(DEPTH),
        .RESET_VEC(0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cur_add    (cur_add),
        .stall      (stall),
        .branch_take(branch_take),
        .branch_off (branch_off),
        .jump       (jump),
        .jump_tgt   (jump_tgt),
        .call       (call),
        .ret        (ret),
        .halt       (halt),
        .next_add   (next_add),
        .halted     (halted),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: 0=boot 1=run 2=halt; the stack is a queue, newest at the back.
    int         m_state;
    logic [4:0] m_q[$];
    bit         m_ovf;
    bit         m_unf;
    logic [4:0] pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        pc    = RV;
    endtask

    function automatic logic [4:0] model_next();
        logic [4:0] r;
        if (m_state == 0) return RV;
        if (m_state == 2 || halt || stall) return cur_add;
        if (ret) begin
            if (RAS_EN && m_q.size() > 0) return m_q[$];
            r = cur_add + 5'd1;
            return r;
        end
        if (call || jump) return jump_tgt;
        if (branch_take) r = cur_add + 5'd1 + branch_off;
        else r = cur_add + 5'd1;
        return r;
    endfunction

    task automatic model_update(input logic [4:0] e);
        logic [4:0] ra;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (halt) begin
                m_state = 2;
            end else if (!stall) begin
                if (ret) begin
                    if (RAS_EN) begin
                        if (m_q.size() > 0) void'(m_q.pop_back());
                        else m_unf = 1'b1;
                    end
                end else if (call && RAS_EN) begin
                    if (m_q.size() == DEPTH) begin
                        void'(m_q.pop_front());
                        m_ovf = 1'b1;
                    end
                    ra = cur_add + 5'd1;
                    m_q.push_back(ra);
                end
            end
        end
        pc = e;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".next_add"}, 32'(next_add), 32'(model_next()));
        chk({tag, ".halted"}, 32'(halted), 32'(m_state == 2));
        chk({tag, ".empty"}, 32'(ras_empty), 32'(m_q.size() == 0));
        chk({tag, ".full"}, 32'(ras_full), 32'(m_q.size() == DEPTH));
        chk({tag, ".ovf"}, 32'(ras_ovf), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(ras_unf), 32'(m_unf));
    endtask

    // One clock cycle: drive, settle, check against model (and a literal when lit >= 0), clock.
    task automatic step(input logic [4:0] ca, input bit st, input bit br, input logic [4:0] off,
                        input bit jp, input logic [4:0] tgt, input bit cl, input bit rt,
                        input bit hl, input int lit, input string tag);
        logic [4:0] e;
        cur_add = ca; stall = st; branch_take = br; branch_off = off;
        jump = jp; jump_tgt = tgt; call = cl; ret = rt; halt = hl;
        #2;
        check_all(tag);
        if (lit >= 0) chk({tag, ".lit"}, 32'(next_add), 32'(lit));
        e = model_next();
        @(posedge clk);
        model_update(e);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".vec"}, 32'(next_add), 32'(RV));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; cur_add = '0; stall = 0; branch_take = 0; branch_off = '0;
        jump = 0; jump_tgt = '0; call = 0; ret = 0; halt = 0;
        model_reset();
        #1;
        do_reset("rst0");

        // Idle fetch from boot through address wrap.
        for (int i = 0; i < 34; i++) step(pc, 0, 0, 0, 0, 0, 0, 0, 0, i % 32, "seq");

        // Relative branches, backward and forward.
        step(5'd10, 0, 1, 5'b11101, 0, 0, 0, 0, 0, 8, "br_neg");
        step(5'd10, 0, 1, 5'd4, 0, 0, 0, 0, 0, 15, "br_pos");

`ifdef NEXT_PC_RAS_EN
        step(5'd3, 0, 0, 0, 0, 5'd20, 1, 0, 0, 20, "call1");
        step(5'd21, 0, 0, 0, 0, 5'd25, 1, 0, 0, 25, "call2");
        step(5'd26, 0, 0, 0, 0, 0, 0, 1, 0, 22, "ret1");
        step(5'd23, 0, 0, 0, 0, 0, 0, 1, 0, 4, "ret2");
        step(5'd4, 0, 0, 0, 0, 0, 0, 0, 0, 5, "after_ret");
        chk("empty_after_pops", 32'(ras_empty), 32'd1);

        do_reset("rst1");
        step(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, "boot1");
        for (int i = 1; i <= 5; i++) step(5'(i), 0, 0, 0, 0, 5'(10 + i), 1, 0, 0, 10 + i, "call5");
        chk("full_after5", 32'(ras_full), 32'd1);
        chk("ovf_after5", 32'(ras_ovf), 32'd1);
        for (int i = 0; i < 4; i++) step(5'd20, 0, 0, 0, 0, 0, 0, 1, 0, 6 - i, "ret4");
        step(5'd20, 0, 0, 0, 0, 0, 0, 1, 0, 21, "ret_unf");
        step(5'd21, 0, 0, 0, 0, 0, 0, 0, 0, 22, "unf_seen");
        chk("unf_sticky", 32'(ras_unf), 32'd1);
`else
        step(5'd3, 0, 0, 0, 0, 5'd20, 1, 0, 0, 20, "call_nr");
        step(5'd20, 0, 0, 0, 0, 0, 0, 1, 0, 21, "ret_nr");
`endif

        // Randomized controls, no halt; pc mostly follows next_add.
        do_reset("rst2");
        for (int i = 0; i < 300; i++) begin
            logic [4:0] ca;
            ca = ($urandom % 4 == 0) ? 5'($urandom) : pc;
            step(ca, ($urandom % 8) == 0, ($urandom % 3) == 0, 5'($urandom),
                 ($urandom % 5) == 0, 5'($urandom), ($urandom % 4) == 0,
                 ($urandom % 5) == 0, 0, -1, "rand");
        end

        // Asynchronous reset in the middle of a call sequence.
        for (int i = 0; i < 3; i++) step(5'(i + 7), 0, 0, 0, 0, 5'd30, 1, 0, 0, 30, "precall");
        call = 1'b1;
        do_reset("midrst");
        step(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, "boot2");

        // Stall holds, halt under stall latches HALT, controls then ignored.
        step(5'd7, 1, 0, 0, 1, 5'd30, 0, 0, 0, 7, "stall_jump");
        step(5'd7, 1, 0, 0, 0, 0, 0, 0, 1, 7, "stall_halt");
        chk("halted_now", 32'(halted), 32'd1);
        step(5'd7, 0, 0, 0, 1, 5'd3, 0, 0, 0, 7, "halt_jump");
        step(5'd7, 0, 1, 5'd4, 0, 0, 1, 0, 0, 7, "halt_call");
        step(5'd12, 0, 0, 0, 0, 0, 0, 1, 0, 12, "halt_ret");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
